// File: rtl/data_mem_responder.sv
// Word-addressed data memory with a fixed number of wait states per access.
// One transaction at a time: IDLE accepts, WAIT counts down, RESP pulses ack.
module data_mem_responder #(
  parameter int ADDR_W = 10,
  parameter int WAIT   = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] write_data,
  input  logic [3:0]  byte_en,
  output logic [31:0] read_data,
  output logic        ack,
  output logic        busy
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

  localparam logic [3:0] WAIT_CNT = 4'(WAIT);
  localparam int         DEPTH    = 1 << ADDR_W;

  state_e              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [3:0]          be_q, be_d;
  logic [31:0]         rdata_q;
  logic                load_rd;
  logic [31:0]         mem [DEPTH];

  // Byte-offset and out-of-range address bits are deliberately dropped.
  logic unused_addr;
  assign unused_addr = ^{addr[31:ADDR_W+2], addr[1:0]};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          we_d    = we;
          idx_d   = addr[ADDR_W+1:2];
          wdata_d = write_data;
          be_d    = byte_en;
          cnt_d   = WAIT_CNT;
          state_d = (WAIT_CNT != 4'd0) ? S_WAIT : S_RESP;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = S_RESP;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Read data is captured on entry to RESP; idx_d/we_d cover the zero-wait path.
  assign load_rd = (state_d == S_RESP) && (state_q != S_RESP) && !we_d;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      rdata_q <= 32'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (load_rd) rdata_q <= mem[idx_d];
    end
  end

  always_ff @(posedge clk) begin
    we_q    <= we_d;
    idx_q   <= idx_d;
    wdata_q <= wdata_d;
    be_q    <= be_d;
  end

  // Memory is never cleared; a reset in RESP suppresses the pending write.
  always_ff @(posedge clk) begin
    if (reset && (state_q == S_RESP) && we_q) begin
      for (int i = 0; i < 4; i++) begin
        if (be_q[i]) mem[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
      end
    end
  end

  assign read_data = rdata_q;
  assign ack       = (state_q == S_RESP);
  assign busy      = (state_q != S_IDLE);

endmodule
